reg_bank_arbiter: RTL and testbench

- Arbitrates the controller register bank (REG_BANK, single port) between two command requesters: port A (UART command path) and port B (SPI slave command path).
- Round-robin grant, one transaction at a time. Sequences the bank write strobe and the read-latency wait, and returns read data and a completion pulse to the owner.
- Sits in the clk_ctrl domain, between the command front-ends and bank1.

---
 rtl/reg_bank_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_bank_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module  : reg_bank_arbiter
// Purpose : Round-robin arbiter sharing the single-port register bank between
//           the UART (A) and SPI (B) command requesters.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reg_bank_arbiter #(
    parameter int ADDR_BITS    = 6,
    parameter int DATA_BITS    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 A_req,
    input  logic                 A_we,
    input  logic [ADDR_BITS-1:0] A_addr,
    input  logic [DATA_BITS-1:0] A_wdata,
    output logic                 A_done,
    output logic [DATA_BITS-1:0] A_rdata,
    input  logic                 B_req,
    input  logic                 B_we,
    input  logic [ADDR_BITS-1:0] B_addr,
    input  logic [DATA_BITS-1:0] B_wdata,
    output logic                 B_done,
    output logic [DATA_BITS-1:0] B_rdata,
    output logic                 bank_WD,
    output logic [ADDR_BITS-1:0] bank_ADDR,
    output logic [DATA_BITS-1:0] bank_DATA_in,
    input  logic [DATA_BITS-1:0] bank_DATA_out,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam bit         c_NO_WAIT   = (READ_LATENCY == 0);
    localparam logic [2:0] c_WAIT_LOAD = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    logic [1:0]           r_state;
    logic                 r_owner;       // 0 = A, 1 = B
    logic                 r_last_owner;
    logic                 r_we;
    logic [2:0]           r_cnt;
    logic                 r_bank_wd;
    logic [ADDR_BITS-1:0] r_bank_addr;
    logic [DATA_BITS-1:0] r_bank_din;
    logic [DATA_BITS-1:0] r_a_rdata;
    logic [DATA_BITS-1:0] r_b_rdata;

    logic w_grant_a;
    logic w_grant_b;
    logic w_any_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_grant_a   = A_req & (~B_req | r_last_owner);
        w_grant_b   = B_req & ~w_grant_a;
        w_any_grant = w_grant_a | w_grant_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_cnt        <= 3'd0;
            r_bank_wd    <= 1'b0;
            r_bank_addr  <= '0;
            r_bank_din   <= '0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_grant) begin
                        r_owner     <= w_grant_b;
                        r_we        <= w_grant_b ? B_we    : A_we;
                        r_bank_wd   <= w_grant_b ? B_we    : A_we;
                        r_bank_addr <= w_grant_b ? B_addr  : A_addr;
                        r_bank_din  <= w_grant_b ? B_wdata : A_wdata;
                        r_state     <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_bank_wd <= 1'b0;
                    if (r_we) begin
                        r_state <= c_DONE;
                    end else if (c_NO_WAIT) begin
                        if (r_owner) r_b_rdata <= bank_DATA_out;
                        else         r_a_rdata <= bank_DATA_out;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_owner) r_b_rdata <= bank_DATA_out;
                        else         r_a_rdata <= bank_DATA_out;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_DONE: begin
                    r_last_owner <= r_owner;
                    r_state      <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign A_done       = (r_state == c_DONE) & ~r_owner;
    assign B_done       = (r_state == c_DONE) &  r_owner;
    assign A_rdata      = r_a_rdata;
    assign B_rdata      = r_b_rdata;
    assign bank_WD      = r_bank_wd;
    assign bank_ADDR    = r_bank_addr;
    assign bank_DATA_in = r_bank_din;
    assign busy         = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// Module  : tb_reg_bank_arbiter
// Purpose : Directed self-checking bench for reg_bank_arbiter (latency 0/1/3).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       A_req, A_we, B_req, B_we, A_done, B_done;
    logic [5:0] A_addr, B_addr, bank_ADDR;
    logic [7:0] A_wdata, B_wdata, A_rdata, B_rdata;
    logic       bank_WD, busy;
    logic [7:0] bank_DATA_in, bank_DATA_out;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_arbiter #(.ADDR_BITS(6), .DATA_BITS(8), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .A_req(A_req), .A_we(A_we), .A_addr(A_addr), .A_wdata(A_wdata),
        .A_done(A_done), .A_rdata(A_rdata),
        .B_req(B_req), .B_we(B_we), .B_addr(B_addr), .B_wdata(B_wdata),
        .B_done(B_done), .B_rdata(B_rdata),
        .bank_WD(bank_WD), .bank_ADDR(bank_ADDR), .bank_DATA_in(bank_DATA_in),
        .bank_DATA_out(bank_DATA_out), .busy(busy)
    );

    // Bank models preload mem[a] = a ^ 0xC3 on reset.
    logic [7:0] mem1 [64];
    logic [7:0] p1;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem1[i] <= 8'(i) ^ 8'hC3;
            p1 <= 8'h00;
        end else begin
            if (bank_WD) mem1[bank_ADDR] <= bank_DATA_in;
            p1 <= mem1[bank_ADDR];
        end
    end
    assign bank_DATA_out = p1;

    logic       l0_req, l0_done, l0_bdone, l0_wd, l0_busy;
    logic [5:0] l0_addr, l0_baddr;
    logic [7:0] l0_rdata, l0_brdata, l0_din, l0_dout;
    reg_bank_arbiter #(.ADDR_BITS(6), .DATA_BITS(8), .READ_LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst),
        .A_req(l0_req), .A_we(1'b0), .A_addr(l0_addr), .A_wdata(8'h00),
        .A_done(l0_done), .A_rdata(l0_rdata),
        .B_req(1'b0), .B_we(1'b0), .B_addr(6'h00), .B_wdata(8'h00),
        .B_done(l0_bdone), .B_rdata(l0_brdata),
        .bank_WD(l0_wd), .bank_ADDR(l0_baddr), .bank_DATA_in(l0_din),
        .bank_DATA_out(l0_dout), .busy(l0_busy)
    );
    logic [7:0] mem0 [64];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem0[i] <= 8'(i) ^ 8'hC3;
        end else if (l0_wd) begin
            mem0[l0_baddr] <= l0_din;
        end
    end
    assign l0_dout = mem0[l0_baddr];

    logic       l3_req, l3_done, l3_bdone, l3_wd, l3_busy;
    logic [5:0] l3_addr, l3_baddr;
    logic [7:0] l3_rdata, l3_brdata, l3_din, l3_dout;
    reg_bank_arbiter #(.ADDR_BITS(6), .DATA_BITS(8), .READ_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .A_req(l3_req), .A_we(1'b0), .A_addr(l3_addr), .A_wdata(8'h00),
        .A_done(l3_done), .A_rdata(l3_rdata),
        .B_req(1'b0), .B_we(1'b0), .B_addr(6'h00), .B_wdata(8'h00),
        .B_done(l3_bdone), .B_rdata(l3_brdata),
        .bank_WD(l3_wd), .bank_ADDR(l3_baddr), .bank_DATA_in(l3_din),
        .bank_DATA_out(l3_dout), .busy(l3_busy)
    );
    logic [7:0] mem3 [64];
    logic [7:0] p3a, p3b, p3c;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 8'(i) ^ 8'hC3;
            p3a <= 8'h00; p3b <= 8'h00; p3c <= 8'h00;
        end else begin
            if (l3_wd) mem3[l3_baddr] <= l3_din;
            p3a <= mem3[l3_baddr];
            p3b <= p3a;
            p3c <= p3b;
        end
    end
    assign l3_dout = p3c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        A_req = 0; A_we = 0; A_addr = 0; A_wdata = 0;
        B_req = 0; B_we = 0; B_addr = 0; B_wdata = 0;
        l0_req = 0; l0_addr = 0; l3_req = 0; l3_addr = 0;
        rst = 1'b0;
        #2;
        tick();
        n_tests++; if ({busy, bank_WD, A_done, B_done} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctl: busy/wd/adone/bdone=%b expected 0000", {busy, bank_WD, A_done, B_done}); end
        n_tests++; if ({bank_ADDR, bank_DATA_in} !== 14'h0) begin n_fail++;
            $display("FAIL reset_bank: addr=%h din=%h expected 00/00", bank_ADDR, bank_DATA_in); end
        n_tests++; if ({A_rdata, B_rdata} !== 16'h0) begin n_fail++;
            $display("FAIL reset_rdata: A=%h B=%h expected 00/00", A_rdata, B_rdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        A_we = 1; A_addr = 6'h05; A_wdata = 8'hA5; A_req = 1;
        tick();
        n_tests++; if ({bank_WD, bank_ADDR, bank_DATA_in} !== {1'b1, 6'h05, 8'hA5}) begin n_fail++;
            $display("FAIL wr_access: wd=%b addr=%h din=%h expected 1/05/A5", bank_WD, bank_ADDR, bank_DATA_in); end
        tick();
        n_tests++; if ({A_done, B_done, bank_WD} !== 3'b100) begin n_fail++;
            $display("FAIL wr_done: adone/bdone/wd=%b expected 100", {A_done, B_done, bank_WD}); end
        A_req = 0;
        tick();
        A_we = 0; A_req = 1;
        tick();
        tick();
        n_tests++; if (A_done !== 1'b0) begin n_fail++;
            $display("FAIL rd_early_done: A_done=%b expected 0 at t+2", A_done); end
        tick();
        n_tests++; if ({A_done, A_rdata, B_rdata} !== {1'b1, 8'hA5, 8'h00}) begin n_fail++;
            $display("FAIL rd_done: done=%b A_rdata=%h B_rdata=%h expected 1/A5/00", A_done, A_rdata, B_rdata); end
        A_req = 0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [3:0] ord;
        int         ndone;
        bit         overlap;
        apply_reset();
        A_we = 1; A_addr = 6'h01; A_wdata = 8'h11; A_req = 1;
        B_we = 1; B_addr = 6'h02; B_wdata = 8'h22; B_req = 1;
        tick();
        n_tests++; if ({bank_WD, bank_ADDR, bank_DATA_in} !== {1'b1, 6'h01, 8'h11}) begin n_fail++;
            $display("FAIL sim_first: wd=%b addr=%h din=%h expected 1/01/11", bank_WD, bank_ADDR, bank_DATA_in); end
        tick();
        n_tests++; if ({A_done, B_done} !== 2'b10) begin n_fail++;
            $display("FAIL sim_adone: A/B done=%b expected 10", {A_done, B_done}); end
        A_req = 0;
        tick();
        tick();
        n_tests++; if ({bank_WD, bank_ADDR, bank_DATA_in} !== {1'b1, 6'h02, 8'h22}) begin n_fail++;
            $display("FAIL sim_second: wd=%b addr=%h din=%h expected 1/02/22", bank_WD, bank_ADDR, bank_DATA_in); end
        tick();
        n_tests++; if ({A_done, B_done} !== 2'b01) begin n_fail++;
            $display("FAIL sim_bdone: A/B done=%b expected 01", {A_done, B_done}); end
        B_req = 0;
        tick();
        n_tests++; if ({mem1[1], mem1[2]} !== 16'h1122) begin n_fail++;
            $display("FAIL sim_mem: mem[1]=%h mem[2]=%h expected 11/22", mem1[1], mem1[2]); end

        A_addr = 6'h10; A_wdata = 8'hAA; B_addr = 6'h11; B_wdata = 8'hBB;
        A_req = 1; B_req = 1;
        ord = 4'b0000; ndone = 0; overlap = 0;
        for (int k = 0; k < 40 && ndone < 4; k++) begin
            tick();
            if (A_done && B_done) overlap = 1;
            if (A_done) begin ord[ndone] = 1'b0; ndone++; end
            else if (B_done) begin ord[ndone] = 1'b1; ndone++; end
        end
        A_req = 0; B_req = 0;
        n_tests++; if (ndone != 4) begin n_fail++;
            $display("FAIL rr_count: %0d completions expected 4", ndone); end
        n_tests++; if ({overlap, ord} !== 5'b0_1010) begin n_fail++;
            $display("FAIL rr_order: overlap=%b order(bit0 first,1=B)=%b expected 0/1010", overlap, ord); end
        tick();
    endtask

    task automatic test_latency();
        int c;
        A_we = 0; A_addr = 6'h20; A_req = 1;
        c = 0;
        do begin tick(); c++; end while (!A_done && c < 20);
        A_req = 0;
        n_tests++; if (c != 3 || A_rdata !== 8'hE3) begin n_fail++;
            $display("FAIL lat1: cycles=%0d data=%h expected 3/E3", c, A_rdata); end
        l0_addr = 6'h07; l0_req = 1;
        c = 0;
        do begin tick(); c++; end while (!l0_done && c < 20);
        l0_req = 0;
        n_tests++; if (c != 2 || l0_rdata !== 8'hC4) begin n_fail++;
            $display("FAIL lat0: cycles=%0d data=%h expected 2/C4", c, l0_rdata); end
        l3_addr = 6'h30; l3_req = 1;
        c = 0;
        do begin tick(); c++; end while (!l3_done && c < 20);
        l3_req = 0;
        n_tests++; if (c != 5 || l3_rdata !== 8'hF3) begin n_fail++;
            $display("FAIL lat3: cycles=%0d data=%h expected 5/F3", c, l3_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        bit saw_wd;
        B_we = 0; B_addr = 6'h09; B_req = 1;
        c = 0;
        do begin tick(); c++; end while (!B_done && c < 20);
        B_req = 0;
        n_tests++; if (B_rdata !== 8'hCA) begin n_fail++;
            $display("FAIL rm_pre: B_rdata=%h expected CA", B_rdata); end
        tick();
        B_addr = 6'h08; B_req = 1;
        tick();
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL rm_busy_wait: busy=%b expected 1", busy); end
        rst = 1'b0;
        #1;
        n_tests++; if ({busy, B_done, bank_WD, B_rdata} !== 11'h0) begin n_fail++;
            $display("FAIL rm_async: busy=%b bdone=%b wd=%b B_rdata=%h expected 0/0/0/00", busy, B_done, bank_WD, B_rdata); end
        tick();
        tick();
        rst = 1'b1;
        c = 0; saw_wd = 0;
        do begin tick(); c++; if (bank_WD) saw_wd = 1; end while (!B_done && c < 20);
        B_req = 0;
        n_tests++; if (c != 3 || B_rdata !== 8'hCB || saw_wd) begin n_fail++;
            $display("FAIL rm_after: cycles=%0d B_rdata=%h wd_seen=%b expected 3/CB/0", c, B_rdata, saw_wd); end
        tick();
    endtask

    task automatic test_early_drop();
        int ndone;
        A_we = 1; A_addr = 6'h3F; A_wdata = 8'hFF; A_req = 1;
        tick();
        A_req = 0; A_we = 0; A_addr = 6'h00; A_wdata = 8'h00;
        n_tests++; if ({bank_WD, bank_ADDR, bank_DATA_in} !== {1'b1, 6'h3F, 8'hFF}) begin n_fail++;
            $display("FAIL drop_access: wd=%b addr=%h din=%h expected 1/3F/FF", bank_WD, bank_ADDR, bank_DATA_in); end
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (A_done) ndone++;
        end
        n_tests++; if (ndone != 1 || mem1[63] !== 8'hFF) begin n_fail++;
            $display("FAIL drop_done: done pulses=%0d mem[3F]=%h expected 1/FF", ndone, mem1[63]); end
    endtask

    task automatic test_back_to_back();
        int nwd, ndone, idx2;
        A_we = 1; A_addr = 6'h12; A_wdata = 8'h34; A_req = 1;
        nwd = 0; ndone = 0; idx2 = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bank_WD) nwd++;
            if (A_done) begin
                ndone++;
                if (ndone == 1) begin
                    A_addr = 6'h13; A_wdata = 8'h56;
                end else begin
                    A_req = 0; idx2 = k;
                end
            end
        end
        A_req = 0;
        n_tests++; if (nwd != 2 || ndone != 2 || idx2 != 5) begin n_fail++;
            $display("FAIL b2b_timing: wd=%0d done=%0d 2nd done at %0d expected 2/2/5", nwd, ndone, idx2); end
        n_tests++; if ({mem1[18], mem1[19]} !== 16'h3456) begin n_fail++;
            $display("FAIL b2b_mem: mem[12]=%h mem[13]=%h expected 34/56", mem1[18], mem1[19]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_latency();
        test_reset_mid();
        test_early_drop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
